// File: rtl/bus_rx_pkg.sv
// Shared types and constants for the tri-state select bus receiver.
package bus_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } rx_state_t;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    localparam int unsigned SETTLE_MIN = 1;
    localparam int unsigned SETTLE_MAX = 15;
    localparam int unsigned SETTLE_CNT_W = 4;

endpackage

// File: rtl/bus_rx_fifo.sv
// Per-channel FIFO with a registered head and same-edge push-through-pop when full.
module bus_rx_fifo
    import bus_rx_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [0:WIDTH-1] push_data,
    input  logic             pop,
    output logic [0:WIDTH-1] head_data,
    output logic             valid,
    output logic             full,
    output logic             ovf_set
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [0:WIDTH-1] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_rp;
    logic [CNT_W-1:0] r_cnt;
    logic [0:WIDTH-1] r_head;
    logic             r_valid;
    logic             r_full;

    logic             w_do_pop;
    logic             w_do_push;
    logic [PTR_W-1:0] w_rp_nxt;
    logic [CNT_W-1:0] w_rem;
    logic [CNT_W-1:0] w_cnt_nxt;

    // A full FIFO still accepts a push when the same edge pops it.
    always_comb begin
        w_do_pop  = pop && r_valid;
        w_do_push = push && (!r_full || w_do_pop);
        w_rp_nxt  = w_do_pop ? r_rp + PTR_W'(1) : r_rp;
        w_rem     = w_do_pop ? r_cnt - CNT_W'(1) : r_cnt;
        w_cnt_nxt = w_do_push ? w_rem + CNT_W'(1) : w_rem;
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wp] <= push_data;
        end
    end

    // Head is refreshed only on pop or on a push into an (effectively) empty FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_head  <= '0;
            r_valid <= 1'b0;
            r_full  <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wp <= r_wp + PTR_W'(1);
            end
            r_rp    <= w_rp_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= (w_cnt_nxt != '0);
            r_full  <= (w_cnt_nxt == CNT_W'(DEPTH));
            if (w_do_push && (w_rem == '0)) begin
                r_head <= push_data;
            end else if (w_do_pop) begin
                r_head <= r_mem[w_rp_nxt];
            end
        end
    end

    assign head_data = r_head;
    assign valid     = r_valid;
    assign full      = r_full;
    assign ovf_set   = push && !w_do_push;

endmodule

// File: rtl/bus_demux_rx.sv
// Samples the shared select bus, qualifies each enabled interval with a settle
// filter and steers one captured byte per interval into channel A or B.
module bus_demux_rx
    import bus_rx_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned DEPTH         = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:WIDTH-1] bus_data,
    input  logic             bus_sel,
    input  logic             bus_en,
    output logic [0:WIDTH-1] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [0:WIDTH-1] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic             ovf_a,
    output logic             ovf_b,
    input  logic             ovf_clr
);

    if (SETTLE_CYCLES < SETTLE_MIN || SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
        $error("bus_demux_rx: SETTLE_CYCLES out of range");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("bus_demux_rx: DEPTH must be a power of 2, at least 2");
    end

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_N = SETTLE_CNT_W'(SETTLE_CYCLES);

    rx_state_t               r_state;
    rx_state_t               w_state_nxt;
    logic [SETTLE_CNT_W-1:0] r_cnt;
    logic [SETTLE_CNT_W-1:0] w_cnt_nxt;
    logic                    r_snap_sel;
    logic                    w_snap_sel_nxt;
    logic [0:WIDTH-1]        r_snap_data;
    logic [0:WIDTH-1]        w_snap_data_nxt;

    logic                    w_push;
    logic                    w_push_sel;
    logic [0:WIDTH-1]        w_push_data;
    logic                    w_ovf_set_a;
    logic                    w_ovf_set_b;
    logic                    w_full_a;
    logic                    w_full_b;
    logic                    w_unused;
    logic                    r_ovf_a;
    logic                    r_ovf_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_snap_sel  <= 1'b0;
            r_snap_data <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_snap_sel  <= w_snap_sel_nxt;
            r_snap_data <= w_snap_data_nxt;
        end
    end

    // bus_en is always tested first so floating data never reaches a compare.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_snap_sel_nxt  = r_snap_sel;
        w_snap_data_nxt = r_snap_data;
        w_push          = 1'b0;
        w_push_sel      = r_snap_sel;
        w_push_data     = r_snap_data;
        case (r_state)
            IDLE: begin
                if (bus_en) begin
                    w_snap_sel_nxt  = bus_sel;
                    w_snap_data_nxt = bus_data;
                    w_cnt_nxt       = SETTLE_CNT_W'(1);
                    if (SETTLE_N == SETTLE_CNT_W'(1)) begin
                        w_push      = 1'b1;
                        w_push_sel  = bus_sel;
                        w_push_data = bus_data;
                        w_state_nxt = HOLD;
                    end else begin
                        w_state_nxt = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (!bus_en) begin
                    w_state_nxt = IDLE;
                end else if ({bus_sel, bus_data} != {r_snap_sel, r_snap_data}) begin
                    w_snap_sel_nxt  = bus_sel;
                    w_snap_data_nxt = bus_data;
                    w_cnt_nxt       = SETTLE_CNT_W'(1);
                end else begin
                    w_cnt_nxt = r_cnt + SETTLE_CNT_W'(1);
                    if (r_cnt + SETTLE_CNT_W'(1) == SETTLE_N) begin
                        w_push      = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!bus_en) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    bus_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push && (w_push_sel == CH_A)),
        .push_data (w_push_data),
        .pop       (a_ready),
        .head_data (a_data),
        .valid     (a_valid),
        .full      (w_full_a),
        .ovf_set   (w_ovf_set_a)
    );

    bus_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push && (w_push_sel == CH_B)),
        .push_data (w_push_data),
        .pop       (b_ready),
        .head_data (b_data),
        .valid     (b_valid),
        .full      (w_full_b),
        .ovf_set   (w_ovf_set_b)
    );

    assign w_unused = w_full_a ^ w_full_b;

    // A new overflow wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_a <= 1'b0;
            r_ovf_b <= 1'b0;
        end else begin
            r_ovf_a <= w_ovf_set_a | (r_ovf_a & ~ovf_clr);
            r_ovf_b <= w_ovf_set_b | (r_ovf_b & ~ovf_clr);
        end
    end

    assign ovf_a = r_ovf_a;
    assign ovf_b = r_ovf_b;

endmodule

// File: tb/tb_bus_demux_rx.sv
// Scoreboard bench for bus_demux_rx with SETTLE_CYCLES=2, DEPTH=2.
module tb_bus_demux_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:7] bus_data;
    logic       bus_sel;
    logic       bus_en;
    logic [0:7] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [0:7] b_data;
    logic       b_valid;
    logic       b_ready;
    logic       ovf_a;
    logic       ovf_b;
    logic       ovf_clr;

    int total = 0;
    int bad   = 0;
    logic [0:7] qa[$];
    logic [0:7] qb[$];

    always #5 clk = ~clk;

    bus_demux_rx #(.WIDTH(8), .SETTLE_CYCLES(2), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .bus_data(bus_data), .bus_sel(bus_sel), .bus_en(bus_en),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .ovf_a(ovf_a), .ovf_b(ovf_b), .ovf_clr(ovf_clr)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one enabled interval of n cycles, then float the bus for one cycle.
    task automatic bus_interval(input logic sel, input logic [0:7] data, input int n);
        bus_en   = 1'b1;
        bus_sel  = sel;
        bus_data = data;
        repeat (n) cyc();
        bus_en   = 1'b0;
        bus_data = 'x;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1; bus_en = 1'b0; bus_sel = 1'b0; bus_data = 'x;
        a_ready = 1'b0; b_ready = 1'b0; ovf_clr = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        total++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid got a=%b b=%b exp 0 0", a_valid, b_valid);
        end
        total++;
        if (a_data !== 8'h00 || b_data !== 8'h00) begin
            bad++; $display("FAIL reset_data got a=%h b=%h exp 00 00", a_data, b_data);
        end
        total++;
        if (ovf_a !== 1'b0 || ovf_b !== 1'b0) begin
            bad++; $display("FAIL reset_ovf got a=%b b=%b exp 0 0", ovf_a, ovf_b);
        end
    endtask

    task automatic test_basic();
        logic [0:7] exp;
        a_ready = 1'b0;
        bus_en = 1'b1; bus_sel = 1'b0; bus_data = 8'hA5;
        qa.push_back(8'hA5);
        cyc();
        total++;
        if (a_valid !== 1'b0) begin
            bad++; $display("FAIL basic_early got a_valid=%b exp 0", a_valid);
        end
        cyc();
        total++;
        if (a_valid !== 1'b1 || a_data !== qa[0]) begin
            bad++; $display("FAIL basic_capture got v=%b d=%h exp v=1 d=%h", a_valid, a_data, qa[0]);
        end
        total++;
        if (b_valid !== 1'b0) begin
            bad++; $display("FAIL basic_b_idle got b_valid=%b exp 0", b_valid);
        end
        cyc();
        bus_en = 1'b0; bus_data = 'x;
        a_ready = 1'b1;
        exp = qa.pop_front();
        total++;
        if (a_valid !== 1'b1 || a_data !== exp) begin
            bad++; $display("FAIL basic_pop got v=%b d=%h exp v=1 d=%h", a_valid, a_data, exp);
        end
        cyc();
        a_ready = 1'b0;
        total++;
        if (a_valid !== 1'b0) begin
            bad++; $display("FAIL basic_after_pop got a_valid=%b exp 0", a_valid);
        end
    endtask

    task automatic test_runt_glitch();
        logic [0:7] exp;
        bus_interval(1'b0, 8'h77, 1);
        cyc();
        total++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            bad++; $display("FAIL runt got a=%b b=%b exp 0 0", a_valid, b_valid);
        end
        bus_en = 1'b1; bus_sel = 1'b0; bus_data = 8'h3C;
        cyc();
        bus_data = 8'h3D;
        qa.push_back(8'h3D);
        cyc(); cyc();
        bus_en = 1'b0; bus_data = 'x;
        a_ready = 1'b1;
        exp = qa.pop_front();
        total++;
        if (a_valid !== 1'b1 || a_data !== exp) begin
            bad++; $display("FAIL glitch_capture got v=%b d=%h exp v=1 d=%h", a_valid, a_data, exp);
        end
        cyc();
        a_ready = 1'b0;
        cyc();
        total++;
        if (a_valid !== 1'b0) begin
            bad++; $display("FAIL glitch_single got a_valid=%b exp 0", a_valid);
        end
    endtask

    task automatic test_one_per_interval();
        int npop = 0;
        logic [0:7] exp;
        b_ready = 1'b0;
        qb.push_back(8'h11);
        bus_interval(1'b1, 8'h11, 10);
        qb.push_back(8'h22);
        bus_interval(1'b1, 8'h22, 2);
        b_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b_valid) begin
                npop++;
                total++;
                if (qb.size() == 0) begin
                    bad++; $display("FAIL interval_extra got b_data=%h exp none", b_data);
                end else begin
                    exp = qb.pop_front();
                    if (b_data !== exp) begin
                        bad++; $display("FAIL interval_order got %h exp %h", b_data, exp);
                    end
                end
            end
            cyc();
        end
        b_ready = 1'b0;
        total++;
        if (npop != 2) begin
            bad++; $display("FAIL interval_count got %0d exp 2", npop);
        end
    endtask

    task automatic test_overflow();
        int npop = 0;
        logic [0:7] exp;
        b_ready = 1'b0;
        qb.push_back(8'h01);
        bus_interval(1'b1, 8'h01, 2);
        qb.push_back(8'h02);
        bus_interval(1'b1, 8'h02, 2);
        bus_interval(1'b1, 8'h03, 2);
        total++;
        if (b_valid !== 1'b1 || b_data !== qb[0] || ovf_b !== 1'b1) begin
            bad++; $display("FAIL ovf_set got v=%b d=%h ovf=%b exp v=1 d=%h ovf=1", b_valid, b_data, ovf_b, qb[0]);
        end
        total++;
        if (ovf_a !== 1'b0) begin
            bad++; $display("FAIL ovf_indep got ovf_a=%b exp 0", ovf_a);
        end
        bus_en = 1'b1; bus_sel = 1'b1; bus_data = 8'h04;
        cyc();
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0; bus_en = 1'b0; bus_data = 'x;
        total++;
        if (ovf_b !== 1'b1) begin
            bad++; $display("FAIL ovf_set_beats_clr got %b exp 1", ovf_b);
        end
        cyc();
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        total++;
        if (ovf_b !== 1'b0) begin
            bad++; $display("FAIL ovf_clr got %b exp 0", ovf_b);
        end
        b_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b_valid) begin
                npop++;
                total++;
                if (qb.size() == 0) begin
                    bad++; $display("FAIL ovf_extra got b_data=%h exp none", b_data);
                end else begin
                    exp = qb.pop_front();
                    if (b_data !== exp) begin
                        bad++; $display("FAIL ovf_order got %h exp %h", b_data, exp);
                    end
                end
            end
            cyc();
        end
        b_ready = 1'b0;
        total++;
        if (npop != 2) begin
            bad++; $display("FAIL ovf_count got %0d exp 2", npop);
        end
    endtask

    task automatic test_full_pop();
        int npop = 0;
        logic [0:7] exp;
        a_ready = 1'b0;
        qa.push_back(8'h41);
        bus_interval(1'b0, 8'h41, 2);
        qa.push_back(8'h42);
        bus_interval(1'b0, 8'h42, 2);
        bus_en = 1'b1; bus_sel = 1'b0; bus_data = 8'h43;
        cyc();
        a_ready = 1'b1;
        exp = qa.pop_front();
        qa.push_back(8'h43);
        total++;
        if (a_valid !== 1'b1 || a_data !== exp) begin
            bad++; $display("FAIL fullpop_head got v=%b d=%h exp v=1 d=%h", a_valid, a_data, exp);
        end
        cyc();
        a_ready = 1'b0; bus_en = 1'b0; bus_data = 'x;
        total++;
        if (ovf_a !== 1'b0) begin
            bad++; $display("FAIL fullpop_ovf got ovf_a=%b exp 0", ovf_a);
        end
        cyc();
        a_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (a_valid) begin
                npop++;
                total++;
                if (qa.size() == 0) begin
                    bad++; $display("FAIL fullpop_extra got a_data=%h exp none", a_data);
                end else begin
                    exp = qa.pop_front();
                    if (a_data !== exp) begin
                        bad++; $display("FAIL fullpop_order got %h exp %h", a_data, exp);
                    end
                end
            end
            cyc();
        end
        a_ready = 1'b0;
        total++;
        if (npop != 2) begin
            bad++; $display("FAIL fullpop_count got %0d exp 2", npop);
        end
    endtask

    task automatic test_async_reset();
        logic [0:7] exp;
        qb.push_back(8'h66);
        bus_interval(1'b1, 8'h66, 2);
        total++;
        if (b_valid !== 1'b1 || b_data !== qb[0]) begin
            bad++; $display("FAIL arst_pre got v=%b d=%h exp v=1 d=%h", b_valid, b_data, qb[0]);
        end
        bus_en = 1'b1; bus_sel = 1'b0; bus_data = 8'h55;
        cyc();
        #2;
        rst = 1'b1; bus_en = 1'b0; bus_data = 'x;
        #1;
        qb.delete();
        total++;
        if (b_valid !== 1'b0 || b_data !== 8'h00 || a_valid !== 1'b0) begin
            bad++; $display("FAIL arst_immediate got bv=%b bd=%h av=%b exp 0 00 0", b_valid, b_data, a_valid);
        end
        #2;
        rst = 1'b0;
        cyc(); cyc(); cyc();
        total++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            bad++; $display("FAIL arst_no_push got a=%b b=%b exp 0 0", a_valid, b_valid);
        end
        qa.push_back(8'h5A);
        bus_interval(1'b0, 8'h5A, 2);
        exp = qa.pop_front();
        total++;
        if (a_valid !== 1'b1 || a_data !== exp) begin
            bad++; $display("FAIL arst_recover got v=%b d=%h exp v=1 d=%h", a_valid, a_data, exp);
        end
        a_ready = 1'b1;
        cyc();
        a_ready = 1'b0;
        total++;
        if (a_valid !== 1'b0) begin
            bad++; $display("FAIL arst_drain got a_valid=%b exp 0", a_valid);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_runt_glitch();
        test_one_per_interval();
        test_overflow();
        test_full_pop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_demux_rx.md
Name: bus_demux_rx

Overview:
- Receive end of the shared 8-bit tri-state select bus. The transmitter drives s ? b : a onto the bus while its enable t is high, and floats the bus otherwise.
- This block samples that bus and qualifies each driven interval with a settle filter. It then steers the captured byte into channel A (sel=0) or channel B (sel=1).
- Each channel is a small FIFO with a valid/ready output.
- Sits between the bus transceiver pins and the two downstream consumers.

Parameters:
- WIDTH, 8: bus data width.
- SETTLE_CYCLES, 2: consecutive identical samples (data and sel, with en high) required before a capture. Legal range is 1..15.
- DEPTH, 2: entries per channel FIFO. Must be a power of 2, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- bus_data  input  [0:WIDTH-1]  bus value; bit 0 is the MSB, matching transmitter ordering.
- bus_sel  input  1  transmitter select: 0 means channel A, 1 means channel B.
- bus_en  input  1  transmitter drive enable; bus_data is meaningful only while this is high.
- a_data  output  [0:WIDTH-1]  head of channel A FIFO.
- a_valid  output  1  channel A head valid.
- a_ready  input  1  channel A consumer accepts; a pop occurs when a_valid and a_ready are both high.
- b_data, b_valid, b_ready: same as the A ports, for channel B.
- ovf_a  output  1  sticky: a channel A byte was dropped because the FIFO was full.
- ovf_b  output  1  sticky: a channel B byte was dropped because the FIFO was full.
- ovf_clr  input  1  synchronous clear of both ovf flags.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; settle counter and snapshot are cleared.
  - Both FIFOs are emptied; a_valid=b_valid=0, a_data=b_data=0, ovf_a=ovf_b=0.
  - Reset mid-SETTLE or mid-HOLD discards the pending byte; nothing is pushed.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE:
  - bus_en=1 at an edge loads snapshot {sel,data} and sets cnt=1.
  - If SETTLE_CYCLES=1, that edge pushes and the FSM goes to HOLD.
  - Otherwise the FSM goes to SETTLE.
- SETTLE:
  - bus_en=0: go to IDLE with no push (runt interval).
  - {sel,data} differs from snapshot: reload snapshot, cnt=1, stay in SETTLE.
  - Otherwise cnt=cnt+1. When cnt reaches SETTLE_CYCLES, push the snapshot to the channel selected by snapshot sel and go to HOLD.
- HOLD:
  - Ignore bus_data and bus_sel.
  - bus_en=0: go to IDLE.
  - At most one byte is captured per bus_en-high interval.
- Latency: with the bus stable from the first enabled edge N, the push happens at edge N+SETTLE_CYCLES-1. x_valid rises after that edge if the FIFO was empty.
- FIFO rules:
  - Push is accepted if count<DEPTH, or if a pop of the same channel occurs on the same edge (full plus simultaneous pop: both happen, count unchanged).
  - Otherwise the byte is dropped and ovf_x is set.
  - Pop while empty is impossible because valid=0.
  - Read and write pointers wrap modulo DEPTH.
  - x_data is the registered head; it is held stable while x_valid=1 and x_ready=0.
- Overflow flags:
  - ovf_clr clears both flags.
  - If an overflow set and ovf_clr occur on the same edge, the flag ends set.
- Channels A and B are fully independent; a push to one never affects the other.
- X/Z on bus_data while bus_en=0 must not affect any state.

Decomposition:
- Package bus_rx_pkg holds:
  - rx_state_t enum {IDLE, SETTLE, HOLD};
  - CH_A=1'b0 and CH_B=1'b1;
  - the SETTLE_CYCLES legality range constants.
- Sub-module bus_rx_fifo (WIDTH, DEPTH) is instantiated twice.
  - Ports: clk, rst, push, push_data, pop, head_data, valid, full, ovf_set.
- The top level contains only the FSM, settle counter, snapshot register and push steering.

Test Plan:
- Basic capture: SETTLE=2; bus_en=1, sel=0, data=8'hA5 held 3 cycles, a_ready=0 → a_valid=1 after the 2nd enabled edge, a_data=A5, b_valid=0. Then a_ready=1 pops; a_valid=0 next cycle.
- Runt and glitch rejection:
  - bus_en high for 1 cycle → no push.
  - Data changes 3C→3D after 1 cycle, then 3D held 2 cycles → exactly one push of 3D.
- One byte per interval: bus_en held 10 cycles with sel=1, data=0x11 → exactly one B entry. bus_en low 1 cycle then high again with 0x22 → second entry 0x22, FIFO order preserved.
- Overflow: b_ready=0, three intervals sel=1 (01, 02, 03) with DEPTH=2 → b_data=01, count 2, ovf_b=1, 03 dropped. ovf_clr asserted on the same edge as a 4th overflow → ovf_b stays 1. Next ovf_clr alone → ovf_b=0.
- Full plus simultaneous pop: FIFO A full, push edge coincides with a_valid&a_ready → push accepted, ovf_a=0, order preserved.
- Async reset mid-SETTLE: rst pulsed between clock edges → outputs 0 immediately without waiting for an edge; no push after release; the next clean interval captures normally.
